vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Produces 640x480@60 Hz VGA timing: the scan-position counters (DrawX, DrawY) that drive the per-pixel color logic, plus the HS/VS/BLANK strobes and a registered RGB output stage that closes the loop from the color logic back to the DAC. Sits between the color-generation path (which consumes DrawX/DrawY and returns 8-bit RGB combinationally) and the board VGA DAC pins.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync and back porch widths (H_TOT = 800)
- V_VIS, 480, visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch, sync and back porch widths (V_TOT = 525)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- In_R, In_G, In_B  in  8 each  color for the current DrawX/DrawY, combinational from color logic
- DrawX  out  10  current horizontal count, 0..799
- DrawY  out  10  current vertical count, 0..524
- Frame_Start  out  1  one-Clk pulse at the start of each frame
- VGA_R, VGA_G, VGA_B  out  8 each  registered DAC color
- VGA_HS, VGA_VS  out  1  active-low syncs
- VGA_BLANK_N  out  1  high while a visible pixel is output
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  DAC pixel clock

## Operation
- Internal pix_en qualifies every state update; no register changes when pix_en = 0.
- Horizontal counter hc: on pix_en, increments; 799 wraps to 0.
- Vertical counter vc: on pix_en with hc = 799, increments; 524 wraps to 0. Otherwise holds.
- DrawX = hc, DrawY = vc, driven directly from the counter registers.
- Output stage, loaded on each pix_en from the pre-increment hc/vc:
  - vis = (hc < 640) && (vc < 480)
  - VGA_R/G/B <= vis ? In_R/G/B : 0
  - VGA_HS <= ~(656 <= hc <= 751)
  - VGA_VS <= ~(490 <= vc <= 491)
  - VGA_BLANK_N <= vis
- Frame_Start: registered. High for exactly one Clk in the cycle after the pix_en edge on which (hc,vc) goes (799,524) to (0,0). Not asserted by leaving reset.
- Reset values (asynchronous on Reset_n low): hc = vc = 0 (so DrawX = DrawY = 0), VGA_R/G/B = 0, VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, Frame_Start = 0, pixel-phase register = 0.
- Reset asserted mid-frame: all of the above take effect immediately. Scan restarts at (0,0) on the first pix_en after release. No partial-line recovery.

## Timing
- Each VGA_* output lags the DrawX/DrawY value it was computed from by exactly one pixel period. Syncs, blank and RGB are mutually aligned.
- In_R/G/B must settle within one Clk from a DrawX/DrawY change. It is sampled only on pix_en edges.
- Line = 800 pixels. HS low for 96 pixels. Frame = 525 lines. VS low for 2 full lines (1600 pixels).
- First visible pixel (0,0) appears on VGA_* one pixel period after DrawX = DrawY = 0.

## Configuration
- VGA_PIXEL_DIV2_EN defined:
  - Pixel clock = Clk/2 (25 MHz).
  - A phase register toggles every Clk (reset 0). pix_en = phase.
  - VGA_CLK = phase, so the DAC samples on the VGA_CLK rising edge, mid-pixel, one Clk after outputs change.
  - One pixel period = 2 Clk.
- VGA_PIXEL_DIV2_EN undefined:
  - pix_en = 1 constantly. Clk must be the pixel clock.
  - VGA_CLK = ~Clk.
  - One pixel period = 1 Clk.
  - The phase register is not present.

## Test plan
- Reset release, with the DIV2 macro defined -> DrawX steps 0,0,1,1,2,... one step per 2 Clk. VGA_HS = 1 until DrawX = 657, then 0 for exactly 192 Clk.
- Full frame run, In_R/G/B = 8'hFF -> VGA_BLANK_N high for exactly 640x480 pixels per frame. VGA_R = 0 whenever VGA_BLANK_N = 0. Frame period = 420000 pixels.
- Counter wrap -> (799,524) is followed by (0,0). Frame_Start high for 1 Clk right after that edge, and low at all other times, including right after reset.
- VS check -> VGA_VS low starting one pixel after DrawY becomes 490 with DrawX = 0, and stays low for exactly 1600 pixels.
- Alignment, In_R = DrawX[7:0] -> at each pixel where VGA_BLANK_N = 1, VGA_R equals the DrawX low byte of the previous pixel.
- Reset_n pulsed low at DrawY = 300 -> outputs return to reset values in the same cycle. After release, scanning restarts at (0,0) and the first VS pulse occurs 490 lines later.

Source files
------------

// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen
// ----------------------------------------------------------------------------
// Produces VGA raster timing, 640x480@60 Hz by default. It has three parts:
//   * Scan-position counters (DrawX/DrawY). The color logic reads these.
//   * HS/VS/BLANK strobes.
//   * A registered RGB stage. It takes the combinational color returned for
//     the current position and presents it to the DAC one pixel later.
//
// Build option:
//   VGA_PIXEL_DIV2_EN  When defined, the pixel clock is Clk/2.
//                      A phase register toggles every Clk and gates all
//                      state updates. VGA_CLK = phase, so the DAC samples
//                      mid-pixel.
//                      When undefined, every Clk is a pixel and
//                      VGA_CLK = ~Clk. No phase register is built.
//
// Ports:
//   Clk              system clock
//   Reset_n          asynchronous active-low reset
//   In_R/In_G/In_B   8-bit color for the current DrawX/DrawY (combinational)
//   DrawX, DrawY     current scan position (0..H_TOT-1, 0..V_TOT-1)
//   Frame_Start      one-Clk pulse after the scan wraps to (0,0)
//   VGA_R/G/B        registered DAC color, zero outside the visible area
//   VGA_HS, VGA_VS   active-low syncs
//   VGA_BLANK_N      high while a visible pixel is presented
//   VGA_SYNC_N       sync-on-green disable, tied low
//   VGA_CLK          DAC pixel clock
// ============================================================================
module vga_sync_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] In_R,
    input  logic [7:0] In_G,
    input  logic [7:0] In_B,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       Frame_Start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // All boundaries are pre-sized to the 10-bit counter width. The sync
    // windows are half-open: [BEG, END).
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic       pix_en;

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic       fstart_q, fstart_d;

    logic       vis;
    logic       at_h_last;
    logic       at_v_last;

    // ------------------------------------------------------------------------
    // Pixel enable / DAC clock
    // ------------------------------------------------------------------------
`ifdef VGA_PIXEL_DIV2_EN
    logic phase_q, phase_d;

    assign phase_d = ~phase_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // State updates happen on the edge that ends the phase=1 half of the
    // pixel. VGA_CLK therefore rises one Clk after the outputs change, which
    // places the DAC sample point in the middle of the pixel.
    assign pix_en  = phase_q;
    assign VGA_CLK = phase_q;
`else
    assign pix_en  = 1'b1;
    // The outputs change on the rising edge of Clk. With the inverted clock,
    // the DAC samples half a period later, once the outputs are stable.
    assign VGA_CLK = ~Clk;
`endif

    assign VGA_SYNC_N = 1'b0;

    // ------------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------------
    assign at_h_last = (hc_q == H_LAST);
    assign at_v_last = (vc_q == V_LAST);

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (at_h_last) begin
                hc_d = '0;
                vc_d = at_v_last ? '0 : (vc_q + 10'd1);
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    // The stage is computed from the pre-increment position. The DAC outputs
    // therefore lag DrawX/DrawY by exactly one pixel. The same lag applies to
    // the color, which was looked up for that same pre-increment position.
    assign vis = (hc_q < H_VIS_C) && (vc_q < V_VIS_C);

    always_comb begin
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (pix_en) begin
            r_d       = vis ? In_R : 8'd0;
            g_d       = vis ? In_G : 8'd0;
            b_d       = vis ? In_B : 8'd0;
            hs_d      = ~((hc_q >= HS_BEG) && (hc_q < HS_END));
            vs_d      = ~((vc_q >= VS_BEG) && (vc_q < VS_END));
            blank_n_d = vis;
        end
    end

    // Frame_Start is updated on every Clk, not only on pix_en edges. In the
    // divided mode this keeps the pulse to one Clk instead of one pixel.
    assign fstart_d = pix_en && at_h_last && at_v_last;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc_q      <= '0;
            vc_q      <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fstart_q  <= fstart_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign Frame_Start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen, using a reduced raster so that several frames fit
// in a short run.
//
// The reference model tracks how many pixel-enable edges have occurred since
// reset release. The scan position, strobes and expected color are derived
// from that pixel index with plain arithmetic.
module tb_vga_sync_gen;

    localparam int HV = 20, HF = 3, HSW = 5, HB = 4;
    localparam int VV = 12, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HV + HF + HSW + HB;   // 32
    localparam int VT = VV + VF + VSW + VB;   // 19
    localparam int FR = HT * VT;              // pixels per frame
`ifdef VGA_PIXEL_DIV2_EN
    localparam int PP = 2;
`else
    localparam int PP = 1;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] In_R, In_G, In_B;
    logic [9:0] DrawX, DrawY;
    logic       Frame_Start;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    vga_sync_gen #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .In_R(In_R), .In_G(In_G), .In_B(In_B),
        .DrawX(DrawX), .DrawY(DrawY), .Frame_Start(Frame_Start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model state
    int         e;            // Clk edges since reset release
    int         n;            // pixel-enable edges since reset release
    logic [7:0] lr, lg, lb;   // color latched at the last pixel edge
    bit         align_mode;

    // Aggregate measurements between consecutive Frame_Start pulses
    bit have_fs;
    int win, blank_cnt, vs_cnt, hs_cnt;
    bit vs_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            if (bad <= 40)
                $error("FAIL %s observed=%0d expected=%0d (e=%0d n=%0d)", tag, obs, exp, e, n);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"},     32'(DrawX), 0);
        chk({tag, "_y"},     32'(DrawY), 0);
        chk({tag, "_r"},     32'(VGA_R), 0);
        chk({tag, "_g"},     32'(VGA_G), 0);
        chk({tag, "_b"},     32'(VGA_B), 0);
        chk({tag, "_hs"},    32'(VGA_HS), 1);
        chk({tag, "_vs"},    32'(VGA_VS), 1);
        chk({tag, "_blank"}, 32'(VGA_BLANK_N), 0);
        chk({tag, "_fs"},    32'(Frame_Start), 0);
        chk({tag, "_vclk"},  32'(VGA_CLK), 0);
    endtask

    task automatic drive_inputs();
        In_R = align_mode ? 8'((n % HT) & 255) : 8'($urandom);
        In_G = 8'($urandom);
        In_B = 8'($urandom);
    endtask

    task automatic tick();
        bit pix;
        int p, px, py;
        bit vis, hs_lo, vs_lo;
        pix = (PP == 1) || (((e + 1) % 2) == 0);
        if (pix) begin
            lr = In_R; lg = In_G; lb = In_B;
        end
        @(posedge Clk);
        #1;
        e++;
        if (pix) n++;

        chk("drawx", 32'(DrawX), 32'(n % HT));
        chk("drawy", 32'(DrawY), 32'((n / HT) % VT));
        if (n == 0) begin
            chk("pre_r", 32'(VGA_R), 0);
            chk("pre_hs", 32'(VGA_HS), 1);
            chk("pre_vs", 32'(VGA_VS), 1);
            chk("pre_blank", 32'(VGA_BLANK_N), 0);
        end else begin
            p     = n - 1;
            px    = p % HT;
            py    = (p / HT) % VT;
            vis   = (px < HV) && (py < VV);
            hs_lo = (px >= HV + HF) && (px < HV + HF + HSW);
            vs_lo = (py >= VV + VF) && (py < VV + VF + VSW);
            chk("vga_r", 32'(VGA_R), vis ? 32'(lr) : 0);
            chk("vga_g", 32'(VGA_G), vis ? 32'(lg) : 0);
            chk("vga_b", 32'(VGA_B), vis ? 32'(lb) : 0);
            chk("hs", 32'(VGA_HS), hs_lo ? 0 : 1);
            chk("vs", 32'(VGA_VS), vs_lo ? 0 : 1);
            chk("blank_n", 32'(VGA_BLANK_N), vis ? 1 : 0);
        end
        chk("frame_start", 32'(Frame_Start), (pix && n > 0 && (n % FR) == 0) ? 1 : 0);
        chk("sync_n", 32'(VGA_SYNC_N), 0);
        chk("vga_clk", 32'(VGA_CLK), (PP == 2) ? 32'(e % 2) : 0);

        if (!vs_seen && VGA_VS === 1'b0) begin
            vs_seen = 1'b1;
            chk("first_vs_edge", 32'(e), 32'(((VV + VF) * HT + 1) * PP));
        end

        if (Frame_Start === 1'b1) begin
            if (have_fs) begin
                chk("frame_period", 32'(win), 32'(FR * PP));
                chk("blank_count", 32'(blank_cnt), 32'(HV * VV * PP));
                chk("vs_low_count", 32'(vs_cnt), 32'(VSW * HT * PP));
                chk("hs_low_count", 32'(hs_cnt), 32'(HSW * VT * PP));
            end
            have_fs = 1'b1;
            win = 0; blank_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        end
        win++;
        if (VGA_BLANK_N === 1'b1) blank_cnt++;
        if (VGA_VS === 1'b0) vs_cnt++;
        if (VGA_HS === 1'b0) hs_cnt++;

        drive_inputs();
    endtask

    task automatic model_restart();
        e = 0; n = 0;
        have_fs = 1'b0; vs_seen = 1'b0;
        win = 0; blank_cnt = 0; vs_cnt = 0; hs_cnt = 0;
    endtask

    initial begin
        bit reached;
        Reset_n = 1'b0;
        In_R = '0; In_G = '0; In_B = '0;
        align_mode = 1'b0;
        lr = '0; lg = '0; lb = '0;
        model_restart();

        // Hold reset for a few clocks, then check the reset state.
        repeat (3) @(posedge Clk);
        #1;
        chk_reset("reset");

        // Release reset away from the active edge, then run random color
        // for two full frames plus a line.
        @(negedge Clk);
        Reset_n = 1'b1;
        drive_inputs();
        for (int i = 0; i < (2 * FR + HT) * PP; i++) tick();

        // Alignment: In_R follows the current DrawX. Run until the scan
        // reaches line 8, which lies mid-frame.
        align_mode = 1'b1;
        drive_inputs();
        reached = 1'b0;
        for (int i = 0; i < 2 * FR * PP; i++) begin
            tick();
            if (((n / HT) % VT) == 8 && (n % HT) == 5) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reach_line8", 32'(reached), 1);

        // Assert reset mid-cycle. Outputs must clear immediately, without
        // waiting for a clock edge.
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset("async_reset");
        repeat (2) begin
            @(posedge Clk);
            #1;
            chk_reset("held_reset");
        end

        // Release reset. The scan must restart at (0,0), and the first VS
        // pulse must follow the full vertical lead-in.
        @(negedge Clk);
        Reset_n = 1'b1;
        model_restart();
        align_mode = 1'b0;
        drive_inputs();
        for (int i = 0; i < (2 * FR + 2 * HT) * PP; i++) tick();
        chk("vs_after_reset", 32'(vs_seen), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
